// File: rtl/imm_extend_unit.sv
// Immediate extension unit: sign/zero/shifted/upper extension of a raw immediate field.
// Latency: 1 clock from accept to out_valid (single registered output stage).
// Backpressure: in_ready = !out_valid || out_ready; the output is held while stalled.
// Optional macro IMM_EXTEND_PREFIX_EN adds the PREFIX mode (upper-half prefix register).
module imm_extend_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16  // must exceed IN_W; with prefix enabled it must be >= 2*IN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [2:0] MODE_SEXT      = 3'd0;
  localparam logic [2:0] MODE_ZEXT      = 3'd1;
  localparam logic [2:0] MODE_SEXT_SHL1 = 3'd2;
  localparam logic [2:0] MODE_UPPER     = 3'd3;

  state_t           state, state_nxt;
  logic             accept;
  logic             produce;
  logic             is_prefix;
  logic [OUT_W-1:0] sext_raw;  // in_imm alone, sign-extended (reserved modes, no prefix)
  logic [OUT_W-1:0] sext_s;    // source S sign-extended
  logic [OUT_W-1:0] zext_s;    // source S zero-extended
  logic [OUT_W-1:0] res_imm;
  logic             res_err;

  assign sext_raw = OUT_W'($signed(in_imm));

`ifdef IMM_EXTEND_PREFIX_EN
  logic [IN_W-1:0]   pfx;
  logic              pend;
  logic [2*IN_W-1:0] wide_s;

  assign wide_s    = {pfx, in_imm};
  assign is_prefix = (in_mode == 3'd4);

  // Source S is the concatenated {P, in_imm} while a prefix is pending
  always_comb begin
    if (pend) begin
      sext_s = OUT_W'($signed(wide_s));
      zext_s = OUT_W'(wide_s);
    end else begin
      sext_s = OUT_W'($signed(in_imm));
      zext_s = OUT_W'(in_imm);
    end
  end

  // Prefix storage: load on PREFIX, any other accepted item consumes/clears pending
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pfx  <= '0;
      pend <= 1'b0;
    end else if (accept) begin
      if (is_prefix) begin
        pfx  <= in_imm;
        pend <= 1'b1;
      end else begin
        pend <= 1'b0;
      end
    end
  end
`else
  assign is_prefix = 1'b0;
  assign sext_s    = OUT_W'($signed(in_imm));
  assign zext_s    = OUT_W'(in_imm);
`endif

  // Result selection by mode; anything unrecognised is flagged and sign-extends in_imm alone
  always_comb begin
    res_imm = sext_raw;
    res_err = 1'b0;
    case (in_mode)
      MODE_SEXT:      res_imm = sext_s;
      MODE_ZEXT:      res_imm = zext_s;
      MODE_SEXT_SHL1: res_imm = sext_s << 1;
      MODE_UPPER:     res_imm = {in_imm, {(OUT_W-IN_W){1'b0}}};
      default: begin
        res_imm = sext_raw;
        res_err = 1'b1;
      end
    endcase
  end

  // Handshake and EMPTY/FULL next-state; PREFIX accepts never fill the output stage
  always_comb begin
    state_nxt = state;
    out_valid = (state == FULL);
    in_ready  = (state == EMPTY) || out_ready;
    accept    = in_valid && in_ready;
    produce   = accept && !is_prefix;
    case (state)
      EMPTY:   if (produce) state_nxt = FULL;
      FULL:    if (out_ready && !produce) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Output data register: loads only on a result-producing accept, otherwise holds
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_imm <= '0;
      out_err <= 1'b0;
    end else if (produce) begin
      out_imm <= res_imm;
      out_err <= res_err;
    end
  end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 SHALL have parameter IN_W, default 8: raw immediate field width.
REQ-002 SHALL have parameter OUT_W, default 16: extended datapath width; legal only if OUT_W >= 2*IN_W.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: upstream presents an immediate.
REQ-006 SHALL have port in_ready, output, 1: unit accepts an immediate this cycle.
REQ-007 SHALL have port in_imm, input, IN_W: raw immediate field.
REQ-008 SHALL have port in_mode, input, 3: 0 SEXT, 1 ZEXT, 2 SEXT_SHL1, 3 UPPER, 4 PREFIX, 5-7 reserved.
REQ-009 SHALL have port out_valid, output, 1: out_imm holds a valid result.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes the result.
REQ-011 SHALL have port out_imm, output, OUT_W: extended immediate.
REQ-012 SHALL have port out_err, output, 1: result came from a reserved mode; qualified by out_valid.

Function
REQ-013 SHALL accept an item when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-014 SHALL register results one stage: out_valid rises the cycle after acceptance; latency 1 clock.
REQ-015 SHALL hold out_imm, out_err and out_valid stable while out_valid && !out_ready.
REQ-016 SHALL clear out_valid after out_valid && out_ready unless a new result-producing item is accepted in the same cycle; in that case, out_valid stays 1 with the new data.
REQ-017 Source S SHALL be in_imm (IN_W bits), or {P, in_imm} (2*IN_W bits) when prefix pending is set and mode is 0-2.
REQ-018 SEXT SHALL output S sign-extended to OUT_W.
REQ-019 ZEXT SHALL output S zero-extended to OUT_W.
REQ-020 SEXT_SHL1 SHALL output (S sign-extended to OUT_W) shifted left 1; the MSB is dropped and bit 0 is 0.
REQ-021 UPPER SHALL output {in_imm, (OUT_W-IN_W) zeros}; it ignores and clears any pending prefix.
REQ-022 PREFIX SHALL load P <= in_imm and set pending; it produces no output and leaves out_valid/out_imm unaffected apart from REQ-016 drain.
REQ-023 A second PREFIX while pending SHALL overwrite P; pending stays set.
REQ-024 Any accepted non-PREFIX item SHALL clear pending in the same edge that registers its result.
REQ-025 Reserved modes SHALL output as SEXT of in_imm alone (pending cleared, prefix not used) with out_err=1; all other results SHALL have out_err=0.
REQ-026 Control state SHALL be EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-027 EMPTY->FULL SHALL occur on a result-producing accept.
REQ-028 FULL->EMPTY SHALL occur on drain without a new result-producing accept.
REQ-029 FULL->FULL SHALL occur on stall or on simultaneous drain and accept.

Reset
REQ-030 On a reset_n=0 clock edge, the unit SHALL set out_valid=0, out_imm=0, out_err=0, pending=0 and P=0, regardless of any handshake in flight.
REQ-031 An item presented in a reset cycle SHALL NOT be accepted; in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-032 Macro IMM_EXTEND_PREFIX_EN defined SHALL compile in P, the pending flag and PREFIX mode, per REQ-017/021-024.
REQ-033 Without IMM_EXTEND_PREFIX_EN, mode 4 SHALL be reserved per REQ-025, S SHALL always be in_imm, and no prefix storage SHALL exist; the OUT_W >= 2*IN_W rule relaxes to OUT_W > IN_W.

Verification (IN_W=8, OUT_W=16, macro defined unless stated)
REQ-034 SEXT 0x80, ZEXT 0x80, SEXT_SHL1 0xC0, UPPER 0x12 back-to-back with out_ready=1 SHALL produce 0xFF80, 0x0080, 0xFF80, 0x1200 on consecutive cycles, starting one cycle after the first accept.
REQ-035 PREFIX 0x12 then SEXT 0x34 SHALL produce 0x1234 and clear pending; a following SEXT 0x34 SHALL produce 0x0034; PREFIX 0xFF then ZEXT 0xFE SHALL produce 0xFFFE.
REQ-036 Holding out_ready=0 for 3 cycles after a result SHALL keep in_ready=0 and out_imm constant; raising out_ready with in_valid=1 SHALL drain and accept in the same cycle, so out_valid stays 1 with the new value.
REQ-037 Mode 6 with in_imm=0x7F SHALL produce 0x007F with out_err=1; without the macro, PREFIX 0x12 SHALL produce 0x0012 with out_err=1.
REQ-038 Asserting reset_n=0 while FULL and prefix pending SHALL yield out_valid=0 next cycle; a subsequent SEXT 0x01 SHALL produce 0x0001.
